// File: rtl/cpu_trace_checker.sv
// Streaming checker for CPU trace lines: parses one ASCII character per clock and
// reports line format, per-field errors and saturating line/error counters.
module cpu_trace_checker #(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter int          NUM_GRF     = 32,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4fff,
    parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic [15:0]      freq,
    output logic [1:0]       format_type,
    output logic [4:0]       error_code,
    output logic [CNT_W-1:0] line_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [3:0] {
        S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON_SP, S_GRF_HDR,
        S_GRF, S_ADDR, S_PRE_ARROW, S_LT, S_POST_ARROW, S_DATA, S_DONE
    } state_t;

    localparam logic [3:0]  TIME_MAX  = 4'(TIME_DIGITS);
    localparam logic [3:0]  GRF_MAX   = 4'(GRF_DIGITS);
    localparam logic [3:0]  HEX_LEN   = 4'd8;
    localparam logic [31:0] GRF_LIMIT = 32'(NUM_GRF);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] time_acc, grf_acc, pc_acc, addr_acc, prev_time;
    logic        prev_valid, is_mem;

    logic        is_dec, is_nz, is_hex, is_sp, line_end;
    logic [3:0]  dec_val, hex_val;
    logic [31:0] half;
    logic [4:0]  err_vec;

    // Range test via 33-bit differences so a zero lower bound needs no special case.
    function automatic logic out_of_range(input logic [31:0] v, input logic [31:0] lo,
                                          input logic [31:0] hi);
        logic [32:0] below, above;
        below = {1'b0, v} - {1'b0, lo};
        above = {1'b0, hi} - {1'b0, v};
        return (v[1:0] != 2'b00) || below[32] || above[32];
    endfunction

    assign is_dec   = (char >= "0") && (char <= "9");
    assign is_nz    = (char >= "1") && (char <= "9");
    assign is_hex   = is_dec || ((char >= "a") && (char <= "f"));
    assign is_sp    = (char == " ");
    assign dec_val  = char[3:0];
    assign hex_val  = (char >= "a") ? char[3:0] + 4'd9 : char[3:0];
    assign line_end = (state == S_DATA) && (cnt == HEX_LEN) && (char == "#");

    always_comb begin
        half    = 32'(freq >> 1);
        err_vec = '0;
        err_vec[0] = (half != 32'd0) && ((time_acc & (half - 32'd1)) != 32'd0);
        err_vec[1] = out_of_range(pc_acc, PC_LO, PC_HI);
        err_vec[2] = is_mem && out_of_range(addr_acc, ADDR_LO, ADDR_HI);
        err_vec[3] = !is_mem && (grf_acc >= GRF_LIMIT);
        err_vec[4] = prev_valid && (time_acc < prev_time);
    end

    // NOTE: all state here is sequential, so every assignment below is non-blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            time_acc    <= '0;
            grf_acc     <= '0;
            pc_acc      <= '0;
            addr_acc    <= '0;
            prev_time   <= '0;
            prev_valid  <= 1'b0;
            is_mem      <= 1'b0;
            format_type <= '0;
            error_code  <= '0;
            line_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            format_type <= '0;
            error_code  <= '0;
            if (char == "^") begin
                state    <= S_CARET;
                cnt      <= '0;
                time_acc <= '0;
            end else begin
                state <= S_IDLE;
                case (state)
                    S_CARET: if (is_nz) begin
                        time_acc <= 32'(dec_val);
                        cnt      <= 4'd1;
                        state    <= S_TIME;
                    end
                    S_TIME: if (is_dec && cnt < TIME_MAX) begin
                        time_acc <= time_acc * 32'd10 + 32'(dec_val);
                        cnt      <= cnt + 4'd1;
                        state    <= S_TIME;
                    end else if (char == "@") begin
                        state <= S_AT;
                    end
                    S_AT: if (is_hex) begin
                        pc_acc <= 32'(hex_val);
                        cnt    <= 4'd1;
                        state  <= S_PC;
                    end
                    S_PC: if (is_hex && cnt < HEX_LEN) begin
                        pc_acc <= {pc_acc[27:0], hex_val};
                        cnt    <= cnt + 4'd1;
                        state  <= S_PC;
                    end else if (char == ":" && cnt == HEX_LEN) begin
                        state <= S_COLON_SP;
                    end
                    S_COLON_SP: if (is_sp) begin
                        state <= S_COLON_SP;
                    end else if (char == "$") begin
                        is_mem <= 1'b0;
                        state  <= S_GRF_HDR;
                    end else if (char == "*") begin
                        is_mem   <= 1'b1;
                        addr_acc <= '0;
                        cnt      <= '0;
                        state    <= S_ADDR;
                    end
                    S_GRF_HDR: if (is_nz) begin
                        grf_acc <= 32'(dec_val);
                        cnt     <= 4'd1;
                        state   <= S_GRF;
                    end
                    S_GRF: if (is_dec && cnt < GRF_MAX) begin
                        grf_acc <= grf_acc * 32'd10 + 32'(dec_val);
                        cnt     <= cnt + 4'd1;
                        state   <= S_GRF;
                    end else if (is_sp) begin
                        state <= S_PRE_ARROW;
                    end else if (char == "<") begin
                        state <= S_LT;
                    end
                    S_ADDR: if (is_hex && cnt < HEX_LEN) begin
                        addr_acc <= {addr_acc[27:0], hex_val};
                        cnt      <= cnt + 4'd1;
                        state    <= S_ADDR;
                    end else if (is_sp && cnt == HEX_LEN) begin
                        state <= S_PRE_ARROW;
                    end else if (char == "<" && cnt == HEX_LEN) begin
                        state <= S_LT;
                    end
                    S_PRE_ARROW: if (is_sp) begin
                        state <= S_PRE_ARROW;
                    end else if (char == "<") begin
                        state <= S_LT;
                    end
                    S_LT: if (char == "=") state <= S_POST_ARROW;
                    S_POST_ARROW: if (is_sp) begin
                        state <= S_POST_ARROW;
                    end else if (is_hex) begin
                        cnt   <= 4'd1;
                        state <= S_DATA;
                    end
                    S_DATA: if (is_hex && cnt < HEX_LEN) begin
                        cnt   <= cnt + 4'd1;
                        state <= S_DATA;
                    end else if (line_end) begin
                        state       <= S_DONE;
                        format_type <= is_mem ? 2'b10 : 2'b01;
                        error_code  <= err_vec;
                        prev_time   <= time_acc;
                        prev_valid  <= 1'b1;
                        if (line_cnt != '1)
                            line_cnt <= line_cnt + CNT_W'(1);
                        if (err_vec != '0 && err_cnt != '1)
                            err_cnt <= err_cnt + CNT_W'(1);
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Self-checking bench: directed trace lines plus randomized lines checked cycle by cycle
// against a string-level reference parser.
module tb_cpu_trace_checker;

    localparam int     TIME_DIGITS = 4;
    localparam int     GRF_DIGITS  = 4;
    localparam longint NUM_GRF     = 32;
    localparam longint PC_LO       = 64'h3000;
    localparam longint PC_HI       = 64'h4fff;
    localparam longint ADDR_LO     = 64'h0;
    localparam longint ADDR_HI     = 64'h2fff;
    localparam int     CNT_MAX     = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  char;
    logic [15:0] freq;
    logic [1:0]  format_type, format_type2, format_type3;
    logic [4:0]  error_code, error_code2, error_code3;
    logic [15:0] line_cnt, err_cnt, line_cnt2, err_cnt2;
    logic [1:0]  line_cnt3, err_cnt3;

    int checks = 0;
    int errors = 0;

    cpu_trace_checker dut (
        .clk(clk), .reset(reset), .char(char), .freq(freq),
        .format_type(format_type), .error_code(error_code),
        .line_cnt(line_cnt), .err_cnt(err_cnt)
    );

    cpu_trace_checker #(.NUM_GRF(64), .PC_HI(32'h0000_7fff)) dut2 (
        .clk(clk), .reset(reset), .char(char), .freq(freq),
        .format_type(format_type2), .error_code(error_code2),
        .line_cnt(line_cnt2), .err_cnt(err_cnt2)
    );

    cpu_trace_checker #(.CNT_W(2)) dut3 (
        .clk(clk), .reset(reset), .char(char), .freq(freq),
        .format_type(format_type3), .error_code(error_code3),
        .line_cnt(line_cnt3), .err_cnt(err_cnt3)
    );

    always #5 clk = ~clk;

    // Reference model state
    string  mbuf = "";
    int     exp_fmt, exp_err, m_line, m_err;
    longint m_prev;
    bit     m_prev_valid;
    logic [1:0] cap_fmt, cap_fmt2;
    logic [4:0] cap_err, cap_err2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_dec(input byte c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic bit is_hex(input byte c);
        return is_dec(c) || (c >= "a" && c <= "f");
    endfunction

    function automatic longint hval(input byte c);
        return is_dec(c) ? longint'(c - "0") : longint'(c - "a" + 10);
    endfunction

    // Whole-line grammar match; v is the register index or the memory address.
    function automatic bit parse(input string s, output int fmt, output longint t,
                                 output longint pc, output longint v);
        int i, k, n;
        n = s.len(); i = 1; fmt = 0; t = 0; pc = 0; v = 0;
        k = 0;
        while (i < n && is_dec(s[i])) begin t = t * 10 + hval(s[i]); i++; k++; end
        if (k < 1 || k > TIME_DIGITS || s[1] == "0") return 0;
        if (i >= n || s[i] != "@") return 0;
        i++; k = 0;
        while (i < n && is_hex(s[i])) begin pc = pc * 16 + hval(s[i]); i++; k++; end
        if (k != 8 || i >= n || s[i] != ":") return 0;
        i++;
        while (i < n && s[i] == " ") i++;
        if (i < n && s[i] == "$") begin
            fmt = 1; i++; k = 0;
            if (i >= n || s[i] == "0") return 0;
            while (i < n && is_dec(s[i])) begin v = v * 10 + hval(s[i]); i++; k++; end
            if (k < 1 || k > GRF_DIGITS) return 0;
        end else if (i < n && s[i] == "*") begin
            fmt = 2; i++; k = 0;
            while (i < n && is_hex(s[i])) begin v = v * 16 + hval(s[i]); i++; k++; end
            if (k != 8) return 0;
        end else begin
            return 0;
        end
        while (i < n && s[i] == " ") i++;
        if (i + 1 >= n || s[i] != "<" || s[i+1] != "=") return 0;
        i += 2;
        while (i < n && s[i] == " ") i++;
        k = 0;
        while (i < n && is_hex(s[i])) begin i++; k++; end
        if (k != 8) return 0;
        return (i == n - 1) && (s[i] == "#");
    endfunction

    task automatic model_step(input byte c, input bit rst);
        int fmt;
        longint t, pc, v, half;
        exp_fmt = 0;
        exp_err = 0;
        if (rst) begin
            mbuf = ""; m_line = 0; m_err = 0; m_prev = 0; m_prev_valid = 0;
            return;
        end
        if (c == "^") mbuf = "^";
        else if (mbuf.len() != 0) mbuf = $sformatf("%s%c", mbuf, c);
        if (c == "#" && mbuf.len() != 0) begin
            if (parse(mbuf, fmt, t, pc, v)) begin
                half = longint'(freq) / 2;
                exp_fmt = fmt;
                if (half != 0 && (t % half) != 0) exp_err |= 1;
                if (pc % 4 != 0 || pc < PC_LO || pc > PC_HI) exp_err |= 2;
                if (fmt == 2 && (v % 4 != 0 || v < ADDR_LO || v > ADDR_HI)) exp_err |= 4;
                if (fmt == 1 && v >= NUM_GRF) exp_err |= 8;
                if (m_prev_valid && t < m_prev) exp_err |= 16;
                m_prev = t;
                m_prev_valid = 1;
                if (m_line < CNT_MAX) m_line++;
                if (exp_err != 0 && m_err < CNT_MAX) m_err++;
            end
            mbuf = "";
        end
    endtask

    task automatic step(input byte c, input bit rst);
        char  = c;
        reset = rst;
        @(posedge clk);
        #1;
        model_step(c, rst);
        check("format_type", 32'(format_type), 32'(exp_fmt));
        check("error_code", 32'(error_code), 32'(exp_err));
        check("line_cnt", 32'(line_cnt), 32'(m_line));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
    endtask

    // Sends a line; rst_pos >= 0 asserts reset while that character is sampled.
    task automatic send_str(input string s, input int rst_pos);
        for (int i = 0; i < s.len(); i++) step(s[i], i == rst_pos);
        cap_fmt  = format_type;
        cap_err  = error_code;
        cap_fmt2 = format_type2;
        cap_err2 = error_code2;
        reset    = 1'b0;
    endtask

    function automatic string spaces(input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = $sformatf("%s ", s);
        return s;
    endfunction

    function automatic string gen_line();
        string s, tstr, mid;
        logic [31:0] pc, addr;
        byte bad;
        case ($urandom_range(0, 11))
            0:       tstr = $sformatf("%0d", $urandom_range(10000, 99999));
            1:       tstr = $sformatf("0%0d", $urandom_range(1, 99));
            default: tstr = $sformatf("%0d", $urandom_range(1, 400));
        endcase
        case ($urandom_range(0, 5))
            0:       pc = 32'h2ffc;
            1:       pc = 32'h3000;
            2:       pc = 32'h4ffc;
            3:       pc = 32'h5000;
            default: pc = $urandom_range(32'h3000, 32'h4fff) & 32'hffff_fffc;
        endcase
        case ($urandom_range(0, 4))
            0:       addr = 32'h0;
            1:       addr = 32'h2ffc;
            2:       addr = 32'h3000;
            default: addr = $urandom_range(0, 32'h2fff) & 32'hffff_fffc;
        endcase
        if ($urandom_range(0, 4) == 0) pc   = pc | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 4) == 0) addr = addr | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) mid = $sformatf("$%0d", $urandom_range(0, 40));
        else                           mid = $sformatf("*%08h", addr);
        s = $sformatf("^%s@%08h:%s%s%s<=%s%08h#", tstr, pc, spaces($urandom_range(0, 2)),
                      mid, spaces($urandom_range(0, 2)), spaces($urandom_range(0, 2)), $urandom);
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 4))
                0:       bad = "X";
                1:       bad = "^";
                2:       bad = " ";
                3:       bad = "#";
                default: bad = "A";
            endcase
            s.putc($urandom_range(1, s.len() - 1), bad);
        end
        return s;
    endfunction

    initial begin
        string s;
        int    rst_pos;
        freq = 16'd4;

        // Reset state
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        check("reset_line_cnt", 32'(line_cnt), 32'd0);
        check("reset_fmt", 32'(format_type), 32'd0);

        // Register line, then memory line with no spaces
        send_str("^10@00003000: $1 <= 0000000a#", -1);
        check("reg_line_fmt", 32'(cap_fmt), 32'd1);
        check("reg_line_err", 32'(cap_err), 32'd0);
        check("reg_line_cnt", 32'(line_cnt), 32'd1);
        step(8'h0a, 1'b0);
        check("done_one_cycle", 32'(format_type), 32'd0);
        send_str("^12@00003004:*00002ffc<=00000001#", -1);
        check("mem_line_fmt", 32'(cap_fmt), 32'd2);
        check("mem_line_err", 32'(cap_err), 32'd0);
        check("mem_line_cnt", 32'(line_cnt), 32'd2);

        // Time, pc and address errors together
        step(8'h00, 1'b1);
        send_str("^3@00003002: *00003000 <= 00000000#", -1);
        check("bad_mem_fmt", 32'(cap_fmt), 32'd2);
        check("bad_mem_err", 32'(cap_err), 32'b00111);
        check("bad_mem_err_cnt", 32'(err_cnt), 32'd1);

        // Register index out of range and time regression
        send_str("^12@00003000: $1 <= 0000000a#", -1);
        send_str("^8@00003000: $40 <= 00000000#", -1);
        check("regress_fmt", 32'(cap_fmt), 32'd1);
        check("regress_err", 32'(cap_err), 32'b11000);
        check("regress_err_cnt", 32'(err_cnt), 32'd2);
        check("sat_line_cnt", 32'(line_cnt3), 32'd3);

        // Resynchronisation, over-long time, reset mid-line
        send_str("^12@^10@00003000: $1 <= 0000000a#", -1);
        check("resync_fmt", 32'(cap_fmt), 32'd1);
        check("resync_err", 32'(cap_err), 32'd0);
        check("resync_line_cnt", 32'(line_cnt), 32'd4);
        send_str("^12345@00003000: $1 <= 0000000a#", -1);
        check("long_time_fmt", 32'(cap_fmt), 32'd0);
        check("long_time_line_cnt", 32'(line_cnt), 32'd4);
        send_str("^10@00003000: $1 <= 0000000a#", 17);
        check("reset_mid_fmt", 32'(cap_fmt), 32'd0);
        check("reset_mid_line_cnt", 32'(line_cnt), 32'd0);
        check("reset_mid_err_cnt", 32'(err_cnt), 32'd0);

        // Overridden parameters with freq=0
        step(8'h00, 1'b1);
        freq = 16'd0;
        send_str("^7@00006000: $40 <= 12345678#", -1);
        check("override_fmt", 32'(cap_fmt2), 32'd1);
        check("override_err", 32'(cap_err2), 32'd0);

        // Randomized lines
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0:       freq = 16'd0;
                1:       freq = 16'd1;
                2:       freq = 16'd2;
                3:       freq = 16'd4;
                4:       freq = 16'd8;
                default: freq = 16'd16;
            endcase
            s = gen_line();
            rst_pos = ($urandom_range(0, 19) == 0) ? $urandom_range(0, s.len() - 1) : -1;
            send_str(s, rst_pos);
            if ($urandom_range(0, 3) == 0) step(8'h0a, 1'b0);
        end
        check("sat3_line_cnt", 32'(line_cnt3), 32'(m_line > 3 ? 3 : m_line));
        check("sat3_err_cnt", 32'(err_cnt3), 32'(m_err > 3 ? 3 : m_err));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
